// File: rtl/sq_anim_pkg.sv
// Shared types and constants for the multi-square animator.
package sq_anim_pkg;

    // Internal coordinate width of a square position.
    localparam int SQ_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        UPD  = 1'b1
    } state_t;

    // One square: signed position plus a direction bit per axis (1 = moving negative).
    typedef struct packed {
        logic signed [SQ_W-1:0] qx;
        logic signed [SQ_W-1:0] qy;
        logic                   dx;
        logic                   dy;
    } sq_t;

    // Square colours as {r, g, b}; index 0 has the highest draw priority.
    localparam logic [23:0] PALETTE [16] = '{
        24'hFF0000, 24'h00FF00, 24'hFFFF00, 24'hFF00FF,
        24'h00FFFF, 24'hFFFFFF, 24'hFF8000, 24'h8000FF,
        24'h80FF00, 24'hFF0080, 24'h00FF80, 24'h808080,
        24'hC04000, 24'h4000C0, 24'h40C000, 24'hC0C040
    };

    localparam logic [23:0] BG_COLOUR = 24'h0080FF;

endpackage

// File: rtl/sq_step.sv
// Combinational next position/direction of a single square for one frame step.
module sq_step
    import sq_anim_pkg::*;
#(
    parameter int H_RES = 800,
    parameter int V_RES = 600,
    parameter int SPEED = 4
) (
    input  sq_t                    cur_i,
    input  logic                   mode_i,
    input  logic signed [SQ_W-1:0] size_i,
    output sq_t                    nxt_o
);

    // One extra bit so edge compares and the speed offset never wrap.
    localparam int W = SQ_W + 1;
    localparam logic signed [W-1:0] SPD = W'(SPEED);

    logic signed [W-1:0] x, y, sz, xlim, ylim, nx, ny;

    // Raster walks x then drops a row; bounce reflects each axis at the edges.
    always_comb begin
        x     = W'($signed(cur_i.qx));
        y     = W'($signed(cur_i.qy));
        sz    = W'(size_i);
        xlim  = W'(H_RES) - sz;
        ylim  = W'(V_RES) - sz;
        nx    = x;
        ny    = y;
        nxt_o = cur_i;
        if (!mode_i) begin
            if (x >= xlim) begin
                nx = '0;
                ny = (y >= ylim) ? '0 : y + sz;
            end else begin
                nx = x + SPD;
            end
        end else begin
            nx = cur_i.dx ? x - SPD : x + SPD;
            ny = cur_i.dy ? y - SPD : y + SPD;
            if (nx > xlim) begin
                nx       = xlim;
                nxt_o.dx = 1'b1;
            end else if (nx[W-1]) begin
                nx       = '0;
                nxt_o.dx = 1'b0;
            end
            if (ny > ylim) begin
                ny       = ylim;
                nxt_o.dy = 1'b1;
            end else if (ny[W-1]) begin
                ny       = '0;
                nxt_o.dy = 1'b0;
            end
        end
        nxt_o.qx = nx[SQ_W-1:0];
        nxt_o.qy = ny[SQ_W-1:0];
    end

endmodule

// File: rtl/multi_square_anim.sv
// Animates N_SQ coloured squares and drives registered VGA pins.
// Positions are stepped one square per cycle during blanking after each i_frame.
module multi_square_anim
    import sq_anim_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int H_RES  = 800,
    parameter int V_RES  = 600,
    parameter int N_SQ   = 4,
    parameter int SIZE_S = 32,
    parameter int SIZE_L = 64,
    parameter int SPEED  = 4
) (
    input  logic                    i_clk_pix,
    input  logic                    i_rst_n,
    input  logic signed [CORDW-1:0] i_sx,
    input  logic signed [CORDW-1:0] i_sy,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
    input  logic                    i_de,
    input  logic                    i_frame,
    input  logic                    i_mode,
    input  logic                    i_size_sel,
    input  logic                    i_pause,
    output logic                    vga_hsync,
    output logic                    vga_vsync,
    output logic                    vga_blank_n,
    output logic                    vga_sync_n,
    output logic [7:0]              vga_r,
    output logic [7:0]              vga_g,
    output logic [7:0]              vga_b,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic [4:0]              qx_hex,
    output logic [4:0]              qy_hex,
    output state_t                  o_state
);

    localparam int IDXW = (N_SQ > 1) ? $clog2(N_SQ) : 1;
    localparam int W    = CORDW + 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_SQ - 1);

    state_t                 state_q, state_d;
    logic [IDXW-1:0]        idx_q, idx_d;
    logic signed [SQ_W-1:0] size_q, size_d;
    logic                   mode_q, mode_d;
    logic                   overrun_q, overrun_d;
    sq_t                    sq_q [N_SQ];
    sq_t                    step_cur, step_nxt;

    logic                   hsync_q, vsync_q, blank_n_q;
    logic [23:0]            rgb_q, colour;

    // Updater control registers.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            size_q    <= SQ_W'(SIZE_S);
            mode_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            size_q    <= size_d;
            mode_q    <= mode_d;
            overrun_q <= overrun_d;
        end
    end

    // Frame pulse latches size/mode and starts the sweep unless paused; a pulse mid-sweep is dropped.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        size_d    = size_q;
        mode_d    = mode_q;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_frame) begin
                    size_d = i_size_sel ? SQ_W'(SIZE_L) : SQ_W'(SIZE_S);
                    mode_d = i_mode;
                    idx_d  = '0;
                    if (!i_pause) state_d = UPD;
                end
            end
            UPD: begin
                if (i_frame) overrun_d = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign step_cur = sq_q[idx_q];

    sq_step #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .SPEED (SPEED)
    ) u_step (
        .cur_i  (step_cur),
        .mode_i (mode_q),
        .size_i (size_q),
        .nxt_o  (step_nxt)
    );

    // Square state: diagonal start layout on reset, one square written per UPD cycle.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_SQ; i++) begin
                sq_q[i].qx <= SQ_W'(i * SIZE_L);
                sq_q[i].qy <= SQ_W'(i * SIZE_L);
                sq_q[i].dx <= 1'b0;
                sq_q[i].dy <= 1'b0;
            end
        end else if (state_q == UPD) begin
            sq_q[idx_q] <= step_nxt;
        end
    end

    // Pixel colour: scan from highest index down so the lowest hit index is left standing.
    always_comb begin
        logic signed [W-1:0] sx_e, sy_e, qx_e, qy_e, sz_e;
        colour = BG_COLOUR;
        sx_e   = W'(i_sx);
        sy_e   = W'(i_sy);
        sz_e   = W'(size_q);
        for (int i = N_SQ - 1; i >= 0; i--) begin
            qx_e = W'($signed(sq_q[i].qx));
            qy_e = W'($signed(sq_q[i].qy));
            if (sx_e >= qx_e && sx_e < qx_e + sz_e && sy_e >= qy_e && sy_e < qy_e + sz_e)
                colour = PALETTE[i];
        end
    end

    // VGA pin registers: everything lags the timing inputs by one pixel clock.
    always_ff @(posedge i_clk_pix) begin
        if (!i_rst_n) begin
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_n_q <= 1'b0;
            rgb_q     <= '0;
        end else begin
            hsync_q   <= i_hsync;
            vsync_q   <= i_vsync;
            blank_n_q <= i_de;
            rgb_q     <= i_de ? colour : '0;
        end
    end

    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b1;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign o_busy      = (state_q == UPD);
    assign o_overrun   = overrun_q;
    assign o_state     = state_q;
    assign qx_hex      = sq_q[0].qx[10:6];
    assign qy_hex      = sq_q[0].qy[10:6];

endmodule
